// File: rtl/amstrad_pkg.sv
// Shared types and constants for the ROM download stager.
// No logic of its own; the page base table is the only mapping knowledge.
package amstrad_pkg;

    localparam int FIFO_DEPTH = 4;

    // SDRAM 16 KiB page bases for ROM slots 0..3 of each model set; slot 3 is the MF2 page.
    localparam logic [8:0] PAGE_BASE_0 = 9'h000;
    localparam logic [8:0] PAGE_BASE_1 = 9'h100;
    localparam logic [8:0] PAGE_BASE_2 = 9'h107;
    localparam logic [8:0] PAGE_BASE_3 = 9'h1FF;

    typedef struct packed {
        logic [22:0] addr;
        logic        bank;
        logic [7:0]  data;
    } fifo_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRAIN,
        ST_DONE
    } stager_state_t;

    function automatic logic [8:0] page_base(input logic [1:0] slot);
        logic [8:0] base;
        case (slot)
            2'd0:    base = PAGE_BASE_0;
            2'd1:    base = PAGE_BASE_1;
            2'd2:    base = PAGE_BASE_2;
            default: base = PAGE_BASE_3;
        endcase
        return base;
    endfunction

endpackage

// File: rtl/stager_fifo.sv
// Four-entry synchronous FIFO; head visible combinationally, push lands next cycle.
// A push while full is refused (caller sees full); pop on empty is ignored.
module stager_fifo
    import amstrad_pkg::*;
(
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        push,
    input  fifo_entry_t push_dat,
    input  logic        pop,
    output fifo_entry_t head_dat,
    output logic [2:0]  count,
    output logic        full,
    output logic        empty
);

    fifo_entry_t mem [FIFO_DEPTH];
    logic [1:0]  wr_ptr;
    logic [1:0]  rd_ptr;
    logic        push_ok;
    logic        pop_ok;

    assign full     = (count == 3'(FIFO_DEPTH));
    assign empty    = (count == 3'd0);
    assign push_ok  = push & ~full;
    assign pop_ok   = pop & ~empty;
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            count  <= 3'd0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 2'd1;
            if (pop_ok)  rd_ptr <= rd_ptr + 2'd1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: nothing is read out unless count says it was written.
    always_ff @(posedge clk_sys) begin
        if (push_ok) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/rom_stager.sv
// Stages host ROM download bytes into SDRAM pages; a byte retires on the first ce_ref slot (<=16 cycles).
// ioctl_wait throttles the host at 3 queued bytes; bytes arriving with the FIFO full or off-map set overrun.
module rom_stager
    import amstrad_pkg::*;
(
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ce_ref,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    output logic        ram_we,
    output logic [22:0] ram_addr,
    output logic        ram_bank,
    output logic [7:0]  ram_din,
    output logic        hold_reset,
    output logic        done,
    output logic        overrun
);

    stager_state_t state;
    stager_state_t state_nxt;

    logic        rom_target;
    logic        accept;
    logic [10:0] page;
    logic        page_ok;
    logic        push_req;
    logic        pop_req;
    logic        load_entry;
    logic        overrun_set;
    fifo_entry_t push_dat;
    fifo_entry_t head_dat;
    logic [2:0]  fifo_count;
    logic        fifo_full;
    logic        fifo_empty;

    assign rom_target = ioctl_download && (ioctl_index == 8'd0);
    assign accept     = ioctl_wr && rom_target;
    assign page       = ioctl_addr[24:14];
    assign page_ok    = (page < 11'd8);
    assign push_req   = accept && page_ok;

    assign push_dat.addr = {page_base(page[1:0]), ioctl_addr[13:0]};
    assign push_dat.bank = page[2];
    assign push_dat.data = ioctl_dout;

    stager_fifo u_fifo (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .push     (push_req),
        .push_dat (push_dat),
        .pop      (pop_req),
        .head_dat (head_dat),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Head is held on the bus until a ce_ref slot takes it; gated to zero when empty.
    assign ram_we     = ~fifo_empty;
    assign ram_addr   = ram_we ? head_dat.addr : 23'd0;
    assign ram_bank   = ram_we ? head_dat.bank : 1'b0;
    assign ram_din    = ram_we ? head_dat.data : 8'd0;
    assign pop_req    = ram_we && ce_ref;
    assign ioctl_wait = (fifo_count >= 3'd3);

    always_ff @(posedge clk_sys) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (rom_target) state_nxt = ST_LOAD;
            ST_LOAD:  if (!ioctl_download) state_nxt = ST_DRAIN;
            ST_DRAIN: begin
                if (ioctl_download)         state_nxt = ST_LOAD;
                else if (fifo_count == 3'd0) state_nxt = ST_DONE;
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    assign hold_reset = (state == ST_LOAD) || (state == ST_DRAIN);
    assign done       = (state == ST_DONE);
    assign load_entry = (state == ST_IDLE) && (state_nxt == ST_LOAD);

    // Setting wins over the entry clear so a bad first byte is still reported.
    assign overrun_set = (accept && !page_ok) || (push_req && fifo_full);

    always_ff @(posedge clk_sys) begin
        if (reset)            overrun <= 1'b0;
        else if (overrun_set) overrun <= 1'b1;
        else if (load_entry)  overrun <= 1'b0;
    end

endmodule

// File: tb/tb_rom_stager.sv
// Directed bench for rom_stager: expected SDRAM writes go to a queue, a forked
// monitor pops and compares each retiring write; control outputs checked inline.
module tb_rom_stager;
    import amstrad_pkg::*;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        ce_ref;
    logic        ioctl_download = 1'b0;
    logic [7:0]  ioctl_index = 8'd0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = 25'd0;
    logic [7:0]  ioctl_dout = 8'd0;
    logic        ioctl_wait;
    logic        ram_we;
    logic [22:0] ram_addr;
    logic        ram_bank;
    logic [7:0]  ram_din;
    logic        hold_reset;
    logic        done;
    logic        overrun;

    logic        ce_auto = 1'b0;
    logic        ce_one = 1'b0;
    logic [3:0]  ce_cnt = 4'd0;

    int          n_checks = 0;
    int          n_pass = 0;
    int          n_writes = 0;
    fifo_entry_t exp_q[$];

    rom_stager dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ce_ref         (ce_ref),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (ioctl_wait),
        .ram_we         (ram_we),
        .ram_addr       (ram_addr),
        .ram_bank       (ram_bank),
        .ram_din        (ram_din),
        .hold_reset     (hold_reset),
        .done           (done),
        .overrun        (overrun)
    );

    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) ce_cnt <= ce_cnt + 4'd1;
    assign ce_ref = ce_auto ? (ce_cnt == 4'd0) : ce_one;

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic expect_write(input logic [22:0] a, input logic b, input logic [7:0] d);
        fifo_entry_t e;
        e.addr = a;
        e.bank = b;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic strobe(input logic [24:0] a, input logic [7:0] d);
        ioctl_download = 1'b1;
        ioctl_wr       = 1'b1;
        ioctl_addr     = a;
        ioctl_dout     = d;
        tick();
        ioctl_wr = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check(name, 32'(seen), 32'd1);
    endtask

    task automatic do_reset();
        ce_auto        = 1'b0;
        ce_one         = 1'b0;
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        reset          = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        bit hr_bad;
        int w0;

        fork
            begin : monitor
                fifo_entry_t e;
                forever begin
                    @(negedge clk_sys);
                    if (ram_we && ce_ref) begin
                        n_writes++;
                        if (exp_q.size() == 0) begin
                            n_checks++;
                            $display("FAIL wr_unexpected: addr %06h bank %0d din %02h, none expected",
                                     ram_addr, ram_bank, ram_din);
                        end else begin
                            e = exp_q.pop_front();
                            check("wr_addr", 32'(ram_addr), 32'(e.addr));
                            check("wr_bank", 32'(ram_bank), 32'(e.bank));
                            check("wr_din",  32'(ram_din),  32'(e.data));
                        end
                    end
                end
            end
            begin : watchdog
                #200000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1, "watchdog");
            end
        join_none

        // Reset state
        do_reset();
        check("rst_ram_we",     32'(ram_we), 0);
        check("rst_hold_reset", 32'(hold_reset), 0);
        check("rst_done",       32'(done), 0);
        check("rst_overrun",    32'(overrun), 0);
        check("rst_wait",       32'(ioctl_wait), 0);
        check("rst_ram_addr",   32'(ram_addr), 0);
        check("rst_ram_bank",   32'(ram_bank), 0);
        check("rst_ram_din",    32'(ram_din), 0);

        // Single byte, page 1, retired by one hand-placed ce_ref
        expect_write(23'h400123, 1'b0, 8'hA5);
        strobe(25'h04123, 8'hA5);
        check("t1_hold_load", 32'(hold_reset), 1);
        check("t1_we_pending", 32'(ram_we), 1);
        ioctl_download = 1'b0;
        tick();
        check("t1_we_held", 32'(ram_we), 1);
        ce_one = 1'b1;
        tick();
        ce_one = 1'b0;
        check("t1_we_retired", 32'(ram_we), 0);
        check("t1_done_early", 32'(done), 0);
        tick();
        check("t1_done_pulse", 32'(done), 1);
        tick();
        check("t1_done_clear", 32'(done), 0);
        check("t1_hold_idle", 32'(hold_reset), 0);

        // Page 6 byte under the free-running 16-cycle slot
        ce_auto = 1'b1;
        expect_write(23'h41C000, 1'b1, 8'h3C);
        strobe(25'h18000, 8'h3C);
        check("t2_hold_load", 32'(hold_reset), 1);
        ioctl_download = 1'b0;
        hr_bad = 1'b0;
        begin : t2_wait
            bit seen = 1'b0;
            for (int i = 0; i < 40; i++) begin
                tick();
                if (done) begin
                    seen = 1'b1;
                    break;
                end
                if (!hold_reset) hr_bad = 1'b1;
            end
            check("t2_done", 32'(seen), 1);
        end
        check("t2_hold_throughout", 32'(hr_bad), 0);
        tick();

        // Burst of 6 with no slots: 4 queued, 2 dropped
        ce_auto = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) expect_write(23'(i), 1'b0, 8'(8'h10 + i));
            strobe(25'(i), 8'(8'h10 + i));
            if (i == 1) check("t3_wait_after2", 32'(ioctl_wait), 0);
            if (i == 2) check("t3_wait_after3", 32'(ioctl_wait), 1);
            if (i == 3) check("t3_overrun_after4", 32'(overrun), 0);
        end
        check("t3_overrun", 32'(overrun), 1);
        ioctl_download = 1'b0;
        w0 = n_writes;
        ce_auto = 1'b1;
        wait_done("t3_done", 120);
        check("t3_write_count", 32'(n_writes - w0), 4);
        check("t3_queue_empty", 32'(exp_q.size()), 0);
        check("t3_overrun_sticky", 32'(overrun), 1);
        tick();

        // Push and retire in the same cycle with two queued
        do_reset();
        expect_write(23'h000010, 1'b0, 8'h55);
        expect_write(23'h000011, 1'b0, 8'h66);
        expect_write(23'h000012, 1'b0, 8'h77);
        strobe(25'h00010, 8'h55);
        strobe(25'h00011, 8'h66);
        check("t4_count_before", 32'(dut.u_fifo.count), 2);
        ce_one = 1'b1;
        strobe(25'h00012, 8'h77);
        ce_one = 1'b0;
        check("t4_count_same", 32'(dut.u_fifo.count), 2);
        check("t4_wr_ptr", 32'(dut.u_fifo.wr_ptr), 3);
        check("t4_rd_ptr", 32'(dut.u_fifo.rd_ptr), 1);
        check("t4_wait_low", 32'(ioctl_wait), 0);
        ioctl_download = 1'b0;
        ce_auto = 1'b1;
        wait_done("t4_done", 60);
        check("t4_queue_empty", 32'(exp_q.size()), 0);
        tick();

        // Off-map page 8: dropped, flagged, session still completes
        ce_auto = 1'b0;
        w0 = n_writes;
        strobe(25'h20000, 8'h99);
        check("t5_overrun", 32'(overrun), 1);
        check("t5_no_we", 32'(ram_we), 0);
        ioctl_download = 1'b0;
        wait_done("t5_done", 10);
        check("t5_no_write", 32'(n_writes - w0), 0);
        tick();

        // Reset in DRAIN with three queued bytes
        strobe(25'h00100, 8'hC1);
        strobe(25'h00101, 8'hC2);
        strobe(25'h00102, 8'hC3);
        ioctl_download = 1'b0;
        tick();
        check("t6_drain_hold", 32'(hold_reset), 1);
        check("t6_count3_wait", 32'(ioctl_wait), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_state_idle", 32'(dut.state), 32'(ST_IDLE));
        check("t6_hold_low", 32'(hold_reset), 0);
        check("t6_we_low", 32'(ram_we), 0);
        w0 = n_writes;
        ce_auto = 1'b1;
        for (int i = 0; i < 40; i++) tick();
        check("t6_no_write", 32'(n_writes - w0), 0);

        check("final_queue_empty", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
